// File: rtl/alu_pkg.sv
// Operation encodings and widths for the shared ALU and its arbiter.
package alu_pkg;
    localparam int XLEN = 32;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] AND  = 4'd2;
    localparam logic [3:0] OR   = 4'd3;
    localparam logic [3:0] XOR  = 4'd4;
    localparam logic [3:0] NOR  = 4'd5;
    localparam logic [3:0] SLT  = 4'd6;
    localparam logic [3:0] SLLV = 4'd7;
    localparam logic [3:0] SRLV = 4'd8;
    localparam logic [3:0] SRA  = 4'd9;
    localparam logic [3:0] SLL  = 4'd10;
    localparam logic [3:0] SRL  = 4'd11;
    localparam logic [3:0] SRAV = 4'd12;
    localparam logic [3:0] SLTU = 4'd13;

    localparam logic [3:0] ALU_ILLEGAL_MIN = 4'd14;

    function automatic logic is_illegal(input logic [3:0] op);
        return op >= ALU_ILLEGAL_MIN;
    endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's request and response channels into the shared ALU.
interface alu_req_if;
    logic                      valid;
    logic                      ready;
    logic [alu_pkg::XLEN-1:0]  a;
    logic [alu_pkg::XLEN-1:0]  b;
    logic [4:0]                c;
    logic [3:0]                aluop;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [alu_pkg::XLEN-1:0]  rsp_data;
    logic                      rsp_illegal;

    modport master (output valid, a, b, c, aluop, rsp_ready,
                    input  ready, rsp_valid, rsp_data, rsp_illegal);
    modport slave  (input  valid, a, b, c, aluop, rsp_ready,
                    output ready, rsp_valid, rsp_data, rsp_illegal);
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU core; illegal opcodes produce zero.
module alu_core
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      c,
    input  logic [3:0]      aluop,
    output logic [XLEN-1:0] y
);
    always_comb begin
        y = '0;
        case (aluop)
            ADD:  y = a + b;
            SUB:  y = a - b;
            AND:  y = a & b;
            OR:   y = a | b;
            XOR:  y = a ^ b;
            NOR:  y = ~(a | b);
            SLT:  y = {31'd0, $signed(a) < $signed(b)};
            SLTU: y = {31'd0, a < b};
            SLLV: y = b << a[4:0];
            SRLV: y = b >> a[4:0];
            SRAV: y = $signed(b) >>> a[4:0];
            SLL:  y = b << c;
            SRL:  y = b >> c;
            SRA:  y = $signed(b) >>> c;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, each with a
// registered response slot (one-cycle latency, drain-and-refill allowed).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    alu_req_if.slave   r0,
    alu_req_if.slave   r1
);
    logic [1:0]           req_valid, rsp_ready, slot_free, elig, grant;
    logic [1:0][XLEN-1:0] req_a, req_b;
    logic [1:0][4:0]      req_c;
    logic [1:0][3:0]      req_op;

    logic [1:0]           rsp_valid, rsp_illegal;
    logic [1:0][XLEN-1:0] rsp_data;
    logic                 prio;

    logic                 sel;
    logic [XLEN-1:0]      alu_y;

    assign req_valid = {r1.valid, r0.valid};
    assign rsp_ready = {r1.rsp_ready, r0.rsp_ready};
    assign req_a     = {r1.a, r0.a};
    assign req_b     = {r1.b, r0.b};
    assign req_c     = {r1.c, r0.c};
    assign req_op    = {r1.aluop, r0.aluop};

    assign slot_free = ~rsp_valid | rsp_ready;
    assign elig      = req_valid & slot_free;

    // Both eligible: prio names the winner; otherwise the lone eligible wins.
    assign grant[0] = elig[0] & (~elig[1] | ~prio);
    assign grant[1] = elig[1] & (~elig[0] |  prio);

    // No grant falls back to requester 0; the result is simply not captured.
    assign sel = grant[1];

    alu_core u_alu (
        .a     (req_a[sel]),
        .b     (req_b[sel]),
        .c     (req_c[sel]),
        .aluop (req_op[sel]),
        .y     (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio        <= INIT_PRIO;
            rsp_valid   <= '0;
            rsp_illegal <= '0;
            rsp_data    <= '0;
        end else begin
            if (|grant) prio <= grant[0];
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_valid[i]   <= 1'b1;
                    rsp_data[i]    <= alu_y;
                    rsp_illegal[i] <= is_illegal(req_op[i]);
                end else if (rsp_ready[i]) begin
                    rsp_valid[i]   <= 1'b0;
                end
            end
        end
    end

    assign r0.ready       = grant[0];
    assign r1.ready       = grant[1];
    assign r0.rsp_valid   = rsp_valid[0];
    assign r1.rsp_valid   = rsp_valid[1];
    assign r0.rsp_data    = rsp_data[0];
    assign r1.rsp_data    = rsp_data[1];
    assign r0.rsp_illegal = rsp_illegal[0];
    assign r1.rsp_illegal = rsp_illegal[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed check of alu_share_arbiter against a cycle-level
// behavioural model of the arbitration and slot rules.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk, rst;
    alu_req_if r0_if ();
    alu_req_if r1_if ();

    alu_share_arbiter #(.INIT_PRIO(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .r0  (r0_if.slave),
        .r1  (r1_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Mirror of what is being driven, plus the reference model state.
    logic        tv [2];
    logic        trr[2];
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    logic [4:0]  tc [2];
    logic [3:0]  top[2];
    logic        m_valid[2];
    logic [31:0] m_data [2];
    logic        m_ill  [2];
    int          m_prio;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] aluref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] c, input logic [3:0] op);
        logic signed [31:0] sb;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return b << a[4:0];
            4'd8:  return b >> a[4:0];
            4'd9:  return sb >>> c;
            4'd10: return b << c;
            4'd11: return b >> c;
            4'd12: return sb >>> a[4:0];
            4'd13: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] c, input logic [3:0] op, input logic rr);
        tv[i] = v; ta[i] = a; tb[i] = b; tc[i] = c; top[i] = op; trr[i] = rr;
        if (i == 0) begin
            r0_if.valid = v; r0_if.a = a; r0_if.b = b; r0_if.c = c;
            r0_if.aluop = op; r0_if.rsp_ready = rr;
        end else begin
            r1_if.valid = v; r1_if.a = a; r1_if.b = b; r1_if.c = c;
            r1_if.aluop = op; r1_if.rsp_ready = rr;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = '0; m_ill[i] = 1'b0;
        end
        m_prio = 0;
    endtask

    task automatic chk_rsp(input string tag);
        chk({tag, "_v0"}, 32'(r0_if.rsp_valid),   32'(m_valid[0]));
        chk({tag, "_v1"}, 32'(r1_if.rsp_valid),   32'(m_valid[1]));
        chk({tag, "_d0"}, r0_if.rsp_data,         m_data[0]);
        chk({tag, "_d1"}, r1_if.rsp_data,         m_data[1]);
        chk({tag, "_i0"}, 32'(r0_if.rsp_illegal), 32'(m_ill[0]));
        chk({tag, "_i1"}, 32'(r1_if.rsp_illegal), 32'(m_ill[1]));
    endtask

    // One clock: check grants against the model, clock, then check slots.
    task automatic step(input string tag);
        bit elig[2];
        int winner;
        #1;
        for (int i = 0; i < 2; i++) elig[i] = tv[i] && (!m_valid[i] || trr[i]);
        if (elig[0] && elig[1]) winner = m_prio;
        else if (elig[0])       winner = 0;
        else if (elig[1])       winner = 1;
        else                    winner = -1;
        chk({tag, "_rdy0"}, 32'(r0_if.ready), 32'(winner == 0));
        chk({tag, "_rdy1"}, 32'(r1_if.ready), 32'(winner == 1));
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (winner == i) begin
                m_valid[i] = 1'b1;
                m_data[i]  = aluref(ta[i], tb[i], tc[i], top[i]);
                m_ill[i]   = (top[i] >= 4'd14);
            end else if (trr[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        if (winner >= 0) m_prio = 1 - winner;
        #1;
        chk_rsp(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req(0, 0, 0, 0, 0, ADD, 1);
        req(1, 0, 0, 0, 0, ADD, 1);
        model_reset();
        #1;
        chk_rsp("rst");
        chk("rst_rdy0", 32'(r0_if.ready), 0);
        chk("rst_rdy1", 32'(r1_if.ready), 0);
        @(negedge clk);
        rst = 1'b0;
        step("idle");

        // Single ADD with wrap-around
        req(0, 1, 32'd7, 32'hFFFF_FFFE, 0, ADD, 1);
        step("add");
        chk("add_data", r0_if.rsp_data, 32'd5);
        req(0, 0, 0, 0, 0, ADD, 1);
        step("add_drain");

        // Contention: grants alternate each cycle
        for (int k = 0; k < 4; k++) begin
            req(0, 1, 32'(k), 32'd100, 0, ADD, 1);
            req(1, 1, 32'(k), 32'd100, 0, SUB, 1);
            step("alt");
        end
        req(0, 0, 0, 0, 0, ADD, 1);
        req(1, 0, 0, 0, 0, ADD, 1);
        step("alt_drain");

        // r1 arithmetic shift, held while its consumer stalls
        req(1, 1, 0, 32'h8000_0000, 5'd4, SRA, 0);
        step("sra");
        chk("sra_data", r1_if.rsp_data, 32'hF800_0000);
        req(1, 1, 32'd1, 32'd2, 0, ADD, 0);
        for (int k = 0; k < 3; k++) begin
            req(0, 1, 32'(k), 32'd9, 0, OR, 1);
            step("sra_hold");
            chk("sra_held", r1_if.rsp_data, 32'hF800_0000);
        end
        req(1, 1, 32'd1, 32'd2, 0, ADD, 1);
        step("sra_release");
        chk("sra_new", r1_if.rsp_data, 32'd3);
        req(0, 0, 0, 0, 0, ADD, 1);
        req(1, 0, 0, 0, 0, ADD, 1);
        step("sra_drain");

        // Illegal op then compares
        req(0, 1, 32'd1, 32'hFFFF_FFFF, 0, 4'd15, 1);
        step("ill");
        chk("ill_flag", 32'(r0_if.rsp_illegal), 1);
        req(0, 1, 32'd1, 32'hFFFF_FFFF, 0, SLTU, 1);
        step("sltu");
        chk("sltu_data", r0_if.rsp_data, 1);
        req(0, 1, 32'd1, 32'hFFFF_FFFF, 0, SLT, 1);
        step("slt");
        chk("slt_data", r0_if.rsp_data, 0);

        // Drain and refill in the same cycle
        req(0, 1, 32'd3, 32'd5, 0, SUB, 1);
        step("refill");
        chk("refill_data", r0_if.rsp_data, 32'hFFFF_FFFE);

        // Reset while a response is held and a grant is pending
        req(0, 0, 0, 0, 0, ADD, 1);
        req(1, 1, 32'd4, 32'd4, 0, XOR, 0);
        step("pre1");
        req(1, 0, 0, 0, 0, ADD, 0);
        req(0, 1, 32'd6, 32'd1, 0, AND, 0);
        step("pre2");
        req(1, 1, 32'd2, 32'd2, 0, ADD, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_rsp("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        req(0, 1, 32'd10, 32'd20, 0, ADD, 1);
        req(1, 1, 32'd10, 32'd20, 0, SUB, 1);
        step("post_rst");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] a, b;
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
                req(i, ($urandom_range(0, 3) != 0), a, b, 5'($urandom), 4'($urandom),
                    ($urandom_range(0, 2) != 0));
            end
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
